// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: registered E/M/W shadow of in-flight writers drives stall and fwd.
// Build option HAZARD_FWD_EN enables forwarding; without it any E/M dependence stalls.
module hazard_ctrl #(
  parameter int unsigned RA_W = 5,
  parameter int unsigned T_W  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] D_rs,
  input  logic [RA_W-1:0] D_rt,
  input  logic            D_need_rs,
  input  logic            D_need_rt,
  input  logic [T_W-1:0]  D_Tuse_rs,
  input  logic [T_W-1:0]  D_Tuse_rt,
  input  logic [T_W-1:0]  D_Tnew,
  input  logic [RA_W-1:0] D_wa,
  input  logic            D_we,
  output logic            stall,
  output logic [1:0]      fwd_D_rs,
  output logic [1:0]      fwd_D_rt,
  output logic [1:0]      fwd_E_rs,
  output logic [1:0]      fwd_E_rt,
  output logic            fwd_M_rt
);

  typedef struct packed {
    logic [RA_W-1:0] wa;
    logic            we;
    logic [T_W-1:0]  tnew;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
  } stage_t;

  stage_t e_q, m_q, w_q;
  stage_t e_d, m_d, w_d;

  function automatic logic [T_W-1:0] dec_sat(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - T_W'(1);
  endfunction

  // $0 is hard-wired, so a stage writing it never produces a dependence.
  function automatic logic hit(input stage_t s, input logic [RA_W-1:0] ra);
    return s.we && (s.wa != '0) && (s.wa == ra);
  endfunction

  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.wa   = D_wa;
      e_d.we   = D_we;
      e_d.tnew = D_Tnew;
      e_d.rs   = D_rs;
      e_d.rt   = D_rt;
    end
    m_d      = e_q;
    m_d.tnew = dec_sat(e_q.tnew);
    w_d      = m_q;
    w_d.tnew = dec_sat(m_q.tnew);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  logic e_rs, m_rs, e_rt, m_rt;
  assign e_rs = D_need_rs && hit(e_q, D_rs);
  assign m_rs = D_need_rs && hit(m_q, D_rs);
  assign e_rt = D_need_rt && hit(e_q, D_rt);
  assign m_rt = D_need_rt && hit(m_q, D_rt);

  logic unused_sig;
  assign unused_sig = ^{D_Tuse_rs, D_Tuse_rt, w_q, m_q.rs, m_q.rt};

`ifdef HAZARD_FWD_EN
  // Nearest stage whose result already exists wins; a pending younger writer is skipped.
  function automatic logic [1:0] d_sel(input logic he, input logic hm, input logic hw,
                                       input logic [T_W-1:0] te, input logic [T_W-1:0] tm,
                                       input logic [T_W-1:0] tw);
    if (he && (te == '0)) return 2'd1;
    else if (hm && (tm == '0)) return 2'd2;
    else if (hw && (tw == '0)) return 2'd3;
    else return 2'd0;
  endfunction

  function automatic logic [1:0] e_sel(input stage_t m, input stage_t w,
                                       input logic [RA_W-1:0] ra);
    if (hit(m, ra) && (m.tnew == '0)) return 2'd2;
    else if (hit(w, ra)) return 2'd3;
    else return 2'd0;
  endfunction

  logic w_rs, w_rt;
  assign w_rs = D_need_rs && hit(w_q, D_rs);
  assign w_rt = D_need_rt && hit(w_q, D_rt);

  always_comb begin
    stall = (e_rs && (e_q.tnew > D_Tuse_rs)) || (m_rs && (m_q.tnew > D_Tuse_rs)) ||
            (e_rt && (e_q.tnew > D_Tuse_rt)) || (m_rt && (m_q.tnew > D_Tuse_rt));
    fwd_D_rs = d_sel(e_rs, m_rs, w_rs, e_q.tnew, m_q.tnew, w_q.tnew);
    fwd_D_rt = d_sel(e_rt, m_rt, w_rt, e_q.tnew, m_q.tnew, w_q.tnew);
    fwd_E_rs = e_sel(m_q, w_q, e_q.rs);
    fwd_E_rt = e_sel(m_q, w_q, e_q.rt);
    fwd_M_rt = hit(w_q, m_q.rt);
  end
`else
  // GRF write-through covers W, so only E and M can hold a value D cannot see yet.
  always_comb begin
    stall    = e_rs || m_rs || e_rt || m_rt;
    fwd_D_rs = 2'd0;
    fwd_D_rt = 2'd0;
    fwd_E_rs = 2'd0;
    fwd_E_rt = 2'd0;
    fwd_M_rt = 1'b0;
  end
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It consumes the per-instruction D-stage descriptors `need_rs`/`need_rt`, `Tuse_rs`/`Tuse_rt` and `Tnew` together with the register addresses. It keeps a registered shadow of the destination register and the remaining Tnew of the instructions in E, M and W. From that shadow it generates the global stall and all forwarding-mux selects, and it sits beside the D/E pipeline register.

## Interface
Parameters:
- `RA_W`, 5, register address width
- `T_W`, 3, width of all Tuse/Tnew fields

Ports:
- `clk` in 1: core clock, rising edge
- `reset` in 1: synchronous, active-low; clears every shadow stage
- `D_rs` in RA_W: rs address of the D-stage instruction
- `D_rt` in RA_W: rt address of the D-stage instruction
- `D_need_rs` in 1: the D-stage instruction reads rs
- `D_need_rt` in 1: the D-stage instruction reads rt
- `D_Tuse_rs` in T_W: cycles until rs is consumed
- `D_Tuse_rt` in T_W: cycles until rt is consumed
- `D_Tnew` in T_W: cycles after entering E until the result exists
- `D_wa` in RA_W: destination register of the D-stage instruction
- `D_we` in 1: the D-stage instruction writes `D_wa`
- `stall` out 1: freeze PC and F/D; insert a bubble into E
- `fwd_D_rs` out 2: D comparator/jr source select; 0=GRF, 1=E, 2=M, 3=W
- `fwd_D_rt` out 2: same encoding as `fwd_D_rs`, for rt
- `fwd_E_rs` out 2: ALU A source select; 0=pipe reg, 2=M, 3=W
- `fwd_E_rt` out 2: ALU B / store data source select; same encoding as `fwd_E_rs`
- `fwd_M_rt` out 1: DM write data select; 0=pipe reg, 1=W

## Operation
- Shadow stages E, M and W each hold `{wa, we, tnew, rs, rt}`. Register $0 never produces a match, whatever the `we` value.
- Each rising edge with `reset`=1 advances the shadow:
  - W <= M with its tnew decremented, saturating at 0.
  - M <= E with its tnew decremented, saturating at 0.
  - When `stall`=0, E <= D inputs with tnew=`D_Tnew`.
  - When `stall`=1, E <= bubble (we=0, wa=0, tnew=0, rs=rt=0).
- Each edge with `reset`=0 clears all three shadow stages to the bubble value.
- A stage matches rs when `D_need_rs`, the stage `we` is 1, the stage `wa` is nonzero, and the stage `wa` equals `D_rs`. rt matching is the same, using `D_need_rt` and `D_rt`.
- Stall condition, with forwarding compiled in:
  - An rs stall occurs when E matches rs with E.tnew > `D_Tuse_rs`, or when M matches rs with M.tnew > `D_Tuse_rs`.
  - rt stalls are computed the same way. `stall` is the OR of the rs and rt stalls.
- D-stage forwarding selects the nearest matching stage whose tnew is 0, in priority order E, then M, then W. If no such stage exists, the select is 0.
- `fwd_E_*` compares the E shadow rs/rt against M (match with M.tnew==0 gives 2), then W (gives 3), otherwise 0.
- `fwd_M_rt` is 1 when the M shadow rt equals W.wa, W.we=1, and W.wa != 0.
- All outputs are combinational from the D inputs and the registered shadow. There are no combinational paths through `stall` into the shadow, except through the E-load select.

## Timing
- Reset values (one edge after `reset`=0, held while low): `stall`=0, every `fwd_*`=0, all shadow fields 0.
- Latency:
  - A new D instruction enters the E shadow on the same edge that clocks the D/E register.
  - `stall` and the selects are valid in the same cycle as the D inputs.
- A load followed by a dependent ALU instruction (Tnew=2, Tuse=1) stalls exactly 1 cycle.
- A load followed by a dependent `beq`/`jr` (Tuse=0) stalls 2 cycles.
- An ALU result followed by a dependent `beq` (Tnew=1, Tuse=0) stalls 1 cycle.
- Simultaneous matches in E and M: the stall is evaluated independently for each stage, and forwarding takes the youngest stage with tnew==0.
- When `reset` goes low mid-stall, the shadow is cleared on that edge and `stall` drops in the next cycle, even if the D inputs still depend on a register.

## Configuration
- `HAZARD_FWD_EN` defined: behaviour as above.
- `HAZARD_FWD_EN` undefined:
  - Every `fwd_*` output is tied to 0.
  - `stall` is asserted whenever the rs or rt match hits E or M, regardless of Tuse/Tnew.
  - W is not checked, because the GRF provides write-through.

## Test plan
- Reset held low for 3 cycles with random D inputs -> `stall`=0 and every `fwd_*`=0. After release, the first edge loads E from the D inputs.
- `lw $3` in D, next D = `addu $4,$3,$5` (Tuse_rs=1) -> `stall`=1 for 1 cycle. On the following cycle `stall`=0 and `fwd_E_rs`=3 once the lw reaches W.
- `lw $3` then `beq $3,$0` -> `stall`=1 for 2 cycles. After that, `fwd_D_rs`=3.
- `ori $2` then `sw $2,0($0)` (rt Tuse=2) -> no stall, and `fwd_M_rt`=1 when the sw is in M and the ori is in W.
- `jal` (wa=31, Tnew=0) then `jr $31` -> no stall, `fwd_D_rs`=1.
- Writer targets $0 (`addu $0,...`) followed by a reader of $0 -> no stall, all selects 0. With `HAZARD_FWD_EN` undefined, `addu $1` then `addu $2,$1,$1` -> `stall`=1 for 2 cycles.
